// File: rtl/edge_event_arbiter.sv
// Rising-edge event capture on NCH level inputs, round-robin arbitration onto a
// single valid/ready event port, with a saturating count of events lost to overflow.
module edge_event_arbiter #(
  parameter int NCH = 4,
  parameter int DCW = 8,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [NCH-1:0] din,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [CW-1:0]  evt_ch,
  output logic [NCH-1:0] pending,
  output logic [DCW-1:0] drop_cnt
);

  localparam int PW = $clog2(NCH + 1);
  localparam int SW = ((DCW > PW) ? DCW : PW) + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t         state;
  logic [NCH-1:0] prev;
  logic [CW-1:0]  last_grant;

  logic [NCH-1:0] rise;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] drops;
  logic [NCH-1:0] pending_next;
  logic           sel_found;
  logic [CW-1:0]  sel_idx;
  logic           grant;
  int unsigned    rr_idx;
  logic [PW-1:0]  ndrop;
  logic [SW-1:0]  drop_sum;
  logic [DCW-1:0] drop_next;

  always_comb begin
    rise      = din & ~prev;
    sel_found = 1'b0;
    sel_idx   = '0;
    rr_idx    = 0;
    // Search begins one past the last grant and wraps around all channels.
    for (int unsigned k = 1; k <= NCH; k++) begin
      rr_idx = 32'(last_grant) + k;
      if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
      if (!sel_found && pending[rr_idx[CW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = rr_idx[CW-1:0];
      end
    end

    grant = sel_found && ((state == IDLE) || evt_ready);
    clr   = '0;
    if (grant) clr[sel_idx] = 1'b1;

    // A rise on a bit being cleared this edge is a fresh event, not a drop.
    pending_next = (pending & ~clr) | rise;
    drops        = rise & pending & ~clr;

    ndrop = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ndrop = ndrop + PW'(drops[i]);
    end
    drop_sum = SW'(drop_cnt) + SW'(ndrop);
    if (drop_sum > SW'({DCW{1'b1}})) drop_next = '1;
    else                             drop_next = drop_sum[DCW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      prev       <= '0;
      pending    <= '0;
      drop_cnt   <= '0;
      evt_valid  <= 1'b0;
      evt_ch     <= '0;
      last_grant <= CW'(NCH - 1);
    end else begin
      prev     <= din;
      pending  <= pending_next;
      drop_cnt <= drop_next;
      case (state)
        IDLE: begin
          if (sel_found) begin
            state      <= OFFER;
            evt_valid  <= 1'b1;
            evt_ch     <= sel_idx;
            last_grant <= sel_idx;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            if (sel_found) begin
              evt_ch     <= sel_idx;
              last_grant <= sel_idx;
            end else begin
              state     <= IDLE;
              evt_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter DCW, default 8, width of the drop counter.
REQ-003 SHALL derive local CW = max(1, clog2(NCH)) as the channel-index width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port din  input  NCH  level inputs, one per channel.
REQ-007 SHALL have port evt_valid  output  1  event offered to the consumer.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts the offered event.
REQ-009 SHALL have port evt_ch  output  CW  channel index of the offered event.
REQ-010 SHALL have port pending  output  NCH  registered per-channel pending flags.
REQ-011 SHALL have port drop_cnt  output  DCW  count of events lost to overflow.

Function
REQ-012 SHALL keep one previous-sample register per channel; rise[i] = din[i] & ~prev[i] at each edge; prev <= din.
REQ-013 SHALL set pending[i] at the edge where rise[i] is true; din held high SHALL produce no further rises.
REQ-014 SHALL use a two-state FSM: IDLE (evt_valid=0) and OFFER (evt_valid=1); evt_valid and evt_ch are registered.
REQ-015 In IDLE with any pending bit set at an edge, SHALL select a channel by round-robin, load evt_ch, clear that pending bit and enter OFFER.
REQ-016 Round-robin search SHALL start at (last_grant+1) mod NCH and wrap; last_grant <= the selected channel.
REQ-017 Latency: rise sampled at edge k sets pending at edge k; with FSM idle, evt_valid SHALL be 1 in the cycle following edge k+1.
REQ-018 In OFFER with evt_ready=0, evt_valid SHALL stay 1 and evt_ch SHALL stay unchanged.
REQ-019 In OFFER with evt_ready=1 at an edge: if any pending bit set, SHALL load the next round-robin channel back-to-back (evt_valid stays 1); else SHALL return to IDLE.
REQ-020 A rise on channel i at the same edge its pending bit is cleared by selection SHALL leave pending[i]=1 (new event, not a drop).
REQ-021 A rise on channel i while pending[i]=1 and not being cleared that edge SHALL be dropped; drop_cnt SHALL add 1 for it.
REQ-022 Multiple simultaneous drops SHALL add their count in one edge; drop_cnt SHALL saturate at 2^DCW-1 and never wrap.
REQ-023 A rise on the channel currently offered (its pending already cleared) SHALL set pending, not drop.
REQ-024 evt_ready while in IDLE SHALL be ignored.

Reset
REQ-025 While resetn=0 at an edge: prev=0, pending=0, drop_cnt=0, FSM=IDLE, evt_valid=0, evt_ch=0, last_grant=NCH-1.
REQ-026 din SHALL be treated as 0 during reset; a din bit high at the first edge after release SHALL count as a rise.
REQ-027 Reset mid-OFFER SHALL discard the offered event without handshake.

Verification (NCH=4, DCW=8)
REQ-028 din=4'b1111 held through reset release, evt_ready=1 -> pending=1111 after first edge; evt_valid continuous 4 cycles, evt_ch 0,1,2,3; then IDLE.
REQ-029 din[2] 0->1 at edge k, held high, evt_ready=1 -> evt_valid=1, evt_ch=2 for exactly one cycle after edge k+1; no further events.
REQ-030 evt_ready=0 for 10 cycles while offering ch1 -> evt_valid=1, evt_ch=1 stable throughout; single completion when evt_ready=1.
REQ-031 evt_ready=0 offering ch0, ch3 pending, ch3 pulsed again -> drop_cnt 0->1; 300 further such drops -> drop_cnt=255 and stays.
REQ-032 Last grant ch2, pending=4'b1001, evt_ready=1 -> ch3 offered before ch0.
REQ-033 resetn=0 for one edge while evt_valid=1, pending=4'b0110, drop_cnt=5 -> next cycle evt_valid=0, pending=0, drop_cnt=0; first post-reset grant order starts at ch0.
